// File: rtl/snowbro2_gfx_fetch.sv
// Tile-word read front-end for one 32-bit SDRAM graphics slot.
// A small direct-mapped cache answers repeated tile-row reads without touching SDRAM.
module snowbro2_gfx_fetch #(
    parameter int AW           = 22,
    parameter int ENTRIES_LOG2 = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          REQ,
    input  logic [AW-1:0] REQ_ADDR,
    output logic          BUSY,
    output logic          RVALID,
    output logic [31:0]   RDATA,
    input  logic          INVALIDATE,
    output logic          SD_CS,
    output logic [AW-1:0] SD_ADDR,
    input  logic          SD_OK,
    input  logic [31:0]   SD_DATA,
    output logic [15:0]   HIT_CNT,
    output logic [15:0]   MISS_CNT
);

    // state | meaning
    // IDLE  | accepting requests, hits answered in one cycle
    // FETCH | slot read outstanding, SD_CS held until SD_OK
    // GAP   | one cycle with SD_CS low before the next request
    typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;

    localparam int NE = 1 << ENTRIES_LOG2;
    localparam int TW = AW - 1 - ENTRIES_LOG2;

    state_t                    state_q;
    logic                      busy_q;
    logic                      rvalid_q;
    logic [31:0]               rdata_q;
    logic                      sd_cs_q;
    logic [AW-1:0]             sd_addr_q;
    logic                      pend_inv_q;
    logic [15:0]               hit_q;
    logic [15:0]               miss_q;
    logic [NE-1:0]             valid_q;
    logic [31:0]               data_q [NE];
    logic [TW-1:0]             tag_q  [NE];

    logic [ENTRIES_LOG2-1:0]   req_idx;
    logic [TW-1:0]             req_tag;
    logic [ENTRIES_LOG2-1:0]   fill_idx;
    logic [TW-1:0]             fill_tag;
    logic                      lookup_hit;
    logic                      fill_en;
    logic                      unused_addr_bit;

    assign req_idx         = REQ_ADDR[ENTRIES_LOG2:1];
    assign req_tag         = REQ_ADDR[AW-1:ENTRIES_LOG2+1];
    assign fill_idx        = sd_addr_q[ENTRIES_LOG2:1];
    assign fill_tag        = sd_addr_q[AW-1:ENTRIES_LOG2+1];
    assign unused_addr_bit = REQ_ADDR[0];

    // A same-cycle invalidate makes every entry look empty to the lookup.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !INVALIDATE;
    assign fill_en    = (state_q == FETCH) && SD_OK;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            sd_cs_q    <= 1'b0;
            sd_addr_q  <= '0;
            pend_inv_q <= 1'b0;
            hit_q      <= 16'h0;
            miss_q     <= 16'h0;
            valid_q    <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        if (lookup_hit) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= data_q[req_idx];
                            if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
                        end else begin
                            state_q   <= FETCH;
                            busy_q    <= 1'b1;
                            sd_cs_q   <= 1'b1;
                            sd_addr_q <= {REQ_ADDR[AW-1:1], 1'b0};
                            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
                        end
                    end
                end
                FETCH: begin
                    if (INVALIDATE) pend_inv_q <= 1'b1;
                    if (SD_OK) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= SD_DATA;
                        sd_cs_q  <= 1'b0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    pend_inv_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sd_cs_q <= 1'b0;
                end
            endcase

            // A fill that raced an invalidate still returns data but stays invalid.
            if (INVALIDATE)
                valid_q <= '0;
            else if (fill_en && !pend_inv_q)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[fill_idx] <= SD_DATA;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign BUSY     = busy_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign SD_CS    = sd_cs_q;
    assign SD_ADDR  = sd_addr_q;
    assign HIT_CNT  = hit_q;
    assign MISS_CNT = miss_q;

endmodule

// File: tb/tb_snowbro2_gfx_fetch.sv
// Bench for snowbro2_gfx_fetch: transaction-level cache model plus directed scenarios.
module tb_snowbro2_gfx_fetch;

    localparam int AW = 22;

    logic          CLK;
    logic          RESET_N;
    logic          REQ;
    logic [AW-1:0] REQ_ADDR;
    logic          BUSY;
    logic          RVALID;
    logic [31:0]   RDATA;
    logic          INVALIDATE;
    logic          SD_CS;
    logic [AW-1:0] SD_ADDR;
    logic          SD_OK;
    logic [31:0]   SD_DATA;
    logic [15:0]   HIT_CNT;
    logic [15:0]   MISS_CNT;

    snowbro2_gfx_fetch #(.AW(AW), .ENTRIES_LOG2(2)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ        (REQ),
        .REQ_ADDR   (REQ_ADDR),
        .BUSY       (BUSY),
        .RVALID     (RVALID),
        .RDATA      (RDATA),
        .INVALIDATE (INVALIDATE),
        .SD_CS      (SD_CS),
        .SD_ADDR    (SD_ADDR),
        .SD_OK      (SD_OK),
        .SD_DATA    (SD_DATA),
        .HIT_CNT    (HIT_CNT),
        .MISS_CNT   (MISS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // ROM contents seen through the slot
    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        if (a == 22'h000010) return 32'hDEADBEEF;
        return ({10'b0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] data;
        bit          fill;
        bit [1:0]    idx;
        bit [18:0]   tag;
        int          due;
    } exp_t;

    bit          mvalid [4];
    bit [18:0]   mtag   [4];
    logic [31:0] mdata  [4];
    logic [15:0] exp_hit  = 16'h0;
    logic [15:0] exp_miss = 16'h0;
    exp_t        expq [$];
    bit          m_active = 1'b0;
    bit          m_cancel = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int          ncyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        expq.delete();
        exp_hit  = 16'h0;
        exp_miss = 16'h0;
        m_active = 1'b0;
        m_cancel = 1'b0;
    endtask

    task automatic model_accept(input logic [AW-1:0] a, input bit inv);
        bit [1:0]  i = a[2:1];
        bit [18:0] t = a[21:3];
        if (inv) for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
        if (mvalid[i] && mtag[i] == t) begin
            if (exp_hit != 16'hFFFF) exp_hit = exp_hit + 16'd1;
            expq.push_back('{data: mdata[i], fill: 1'b0, idx: i, tag: t, due: ncyc + 1});
        end else begin
            if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
            m_active = 1'b1;
            m_cancel = 1'b0;
            m_addr   = {a[21:1], 1'b0};
            expq.push_back('{data: mem({a[21:1], 1'b0}), fill: 1'b1, idx: i, tag: t, due: -1});
        end
    endtask

    // ---------------- slot responder ----------------
    int sd_lat      = 5;
    bit sd_force_ok = 1'b0;
    int sd_cnt      = 0;

    initial begin
        SD_OK   = 1'b0;
        SD_DATA = 32'h0;
        forever begin
            @(negedge CLK);
            SD_DATA = mem(SD_ADDR);
            if (SD_CS === 1'b1) sd_cnt++;
            else sd_cnt = 0;
            SD_OK = sd_force_ok || (sd_lat != 0 && sd_cnt == sd_lat);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        exp_t e;
        ncyc++;
        if (RESET_N === 1'b1) begin
            chk("hit_cnt", 32'(HIT_CNT), 32'(exp_hit));
            chk("miss_cnt", 32'(MISS_CNT), 32'(exp_miss));
            if (RVALID === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL rvalid_unexpected: got RVALID=1 expected 0");
                end else begin
                    e = expq.pop_front();
                    chk("rdata", RDATA, e.data);
                    if (e.due >= 0) chk("hit_latency", 32'(ncyc), 32'(e.due));
                    if (e.fill) begin
                        mdata[e.idx]  = e.data;
                        mtag[e.idx]   = e.tag;
                        mvalid[e.idx] = !m_cancel;
                        m_cancel      = 1'b0;
                        m_active      = 1'b0;
                    end
                end
            end
            if (SD_CS !== 1'b0) begin
                chk("sd_cs_expected", 32'(m_active), 32'd1);
                chk("sd_addr", 32'(SD_ADDR), 32'(m_addr));
            end
        end
    end

    // ---------------- activity monitor ----------------
    int cs_bursts = 0, cur_len = 0, last_len = 0, busy_nocs = 0, rv_total = 0, rv_b2b = 0;
    logic [AW-1:0] last_cs_addr = '0;
    bit prev_cs = 1'b0, prev_rv = 1'b0;

    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (SD_CS === 1'b1) begin
                if (!prev_cs) begin
                    cs_bursts++;
                    cur_len = 0;
                end
                cur_len++;
                last_cs_addr = SD_ADDR;
            end else if (prev_cs) begin
                last_len = cur_len;
            end
            if (BUSY === 1'b1 && SD_CS === 1'b0) busy_nocs++;
            if (RVALID === 1'b1) begin
                rv_total++;
                if (prev_rv) rv_b2b++;
            end
        end
        prev_cs = (SD_CS === 1'b1);
        prev_rv = (RVALID === 1'b1);
    end

    // ---------------- stimulus tasks ----------------
    task automatic req(input logic [AW-1:0] a, input bit inv = 1'b0);
        int guard = 0;
        while (BUSY !== 1'b0) begin
            @(negedge CLK);
            guard++;
            if (guard > 200) begin
                fail_timeout("req_wait_busy");
                return;
            end
        end
        REQ        = 1'b1;
        REQ_ADDR   = a;
        INVALIDATE = inv;
        @(posedge CLK);
        model_accept(a, inv);
        @(negedge CLK);
        REQ        = 1'b0;
        INVALIDATE = 1'b0;
    endtask

    task automatic invalidate();
        INVALIDATE = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
        if (m_active) m_cancel = 1'b1;
        @(negedge CLK);
        INVALIDATE = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(BUSY === 1'b0 && expq.size() == 0)) begin
            @(negedge CLK);
            guard++;
            if (guard > 200) begin
                fail_timeout("wait_idle");
                break;
            end
        end
        @(negedge CLK);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    int b, g, r, rv0;

    initial begin
        RESET_N    = 1'b1;
        REQ        = 1'b0;
        REQ_ADDR   = '0;
        INVALIDATE = 1'b0;
        model_reset();
        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy",   32'(BUSY),     32'd0);
        chk("rst_rvalid", 32'(RVALID),   32'd0);
        chk("rst_rdata",  RDATA,         32'h0);
        chk("rst_sd_cs",  32'(SD_CS),    32'd0);
        chk("rst_sd_addr",32'(SD_ADDR),  32'h0);
        chk("rst_hit",    32'(HIT_CNT),  32'h0);
        chk("rst_miss",   32'(MISS_CNT), 32'h0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // single miss, slot answers in the fifth CS cycle
        sd_lat = 5;
        b = cs_bursts; g = busy_nocs;
        req(22'h000010);
        wait_idle();
        chk("t1_cs_len",  32'(last_len),        32'd5);
        chk("t1_cs_addr", 32'(last_cs_addr),    32'h10);
        chk("t1_bursts",  32'(cs_bursts - b),   32'd1);
        chk("t1_gap",     32'(busy_nocs - g),   32'd1);
        chk("t1_rdata",   RDATA,                32'hDEADBEEF);
        chk("t1_miss",    32'(MISS_CNT),        32'd1);

        // back-to-back hits, including the odd word address
        b = cs_bursts; r = rv_b2b;
        req(22'h000010);
        req(22'h000011);
        wait_idle();
        chk("t2_hit",     32'(HIT_CNT),         32'd2);
        chk("t2_no_cs",   32'(cs_bursts - b),   32'd0);
        chk("t2_b2b",     32'(rv_b2b - r),      32'd1);
        chk("t2_rdata",   RDATA,                32'hDEADBEEF);

        // same-index eviction
        b = cs_bursts; g = busy_nocs;
        req(22'h000030);
        wait_idle();
        req(22'h000010);
        wait_idle();
        chk("t3_miss",    32'(MISS_CNT),        32'd3);
        chk("t3_bursts",  32'(cs_bursts - b),   32'd2);
        chk("t3_gap",     32'(busy_nocs - g),   32'd2);
        chk("t3_rdata",   RDATA,                32'hDEADBEEF);

        // invalidate during a fetch, and a request ignored while busy
        sd_lat = 6;
        req(22'h000002);
        @(negedge CLK);
        invalidate();
        wait_idle();
        req(22'h000010);
        REQ = 1'b1; REQ_ADDR = 22'h000010;
        @(negedge CLK);
        REQ = 1'b0;
        wait_idle();
        req(22'h000002);
        wait_idle();
        chk("t4_miss",    32'(MISS_CNT),        32'd6);
        chk("t4_hit",     32'(HIT_CNT),         32'd2);
        chk("t4_rv_total",32'(rv_total),        32'd8);

        // invalidate in the same cycle as a request forces a miss
        req(22'h000002, 1'b1);
        wait_idle();
        req(22'h000002);
        wait_idle();
        chk("t4b_miss",   32'(MISS_CNT),        32'd7);
        chk("t4b_hit",    32'(HIT_CNT),         32'd3);

        // reset in the middle of a fetch
        sd_lat = 0;
        req(22'h000040);
        repeat (2) @(negedge CLK);
        chk("t5_cs_before", 32'(SD_CS), 32'd1);
        #2 RESET_N = 1'b0;
        #1 chk("t5_cs_async", 32'(SD_CS), 32'd0);
        model_reset();
        sd_force_ok = 1'b1;
        repeat (2) @(negedge CLK);
        rv0 = rv_total;
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("t5_no_rvalid", 32'(rv_total - rv0), 32'd0);
        sd_force_ok = 1'b0;
        @(negedge CLK);
        sd_lat = 3;
        req(22'h000010);
        wait_idle();
        chk("t5_miss",    32'(MISS_CNT),        32'd1);
        chk("t5_hit",     32'(HIT_CNT),         32'd0);
        chk("t5_rdata",   RDATA,                32'hDEADBEEF);

        // hit counter saturation
        @(posedge CLK);
        #2 force dut.hit_q = 16'hFFFB;
        exp_hit = 16'hFFFB;
        #1 release dut.hit_q;
        @(negedge CLK);
        repeat (3) req(22'h000010);
        wait_idle();
        chk("t6_hit_fffe", 32'(HIT_CNT), 32'hFFFE);
        repeat (2) req(22'h000010);
        wait_idle();
        chk("t6_hit_sat",  32'(HIT_CNT), 32'hFFFF);
        chk("t6_miss",     32'(MISS_CNT), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule
